// File: rtl/freq_meter.sv
// Counts synchronised rising edges of sig_in_i over a programmable clk window and flags
// lock when the count lies within tol of the expected value.
module freq_meter #(
  parameter int unsigned GATE_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sig_in_i,
  input  logic              start_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic [CNT_W-1:0]  expect_i,
  input  logic [CNT_W-1:0]  tol_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              lock_o
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, prev_q;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  exp_q, exp_d, tol_q, tol_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d, valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d, lock_q, lock_d;
  logic [CNT_W-1:0]  diff;

  assign rise = s2_q & ~prev_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    exp_d      = exp_q;
    tol_d      = tol_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    lock_d     = lock_q;
    diff       = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i && (gate_len_i != '0)) begin
          state_d    = StGate;
          gate_cnt_d = gate_len_i;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          exp_d      = expect_i;
          tol_d      = tol_i;
        end
      end
      StGate: begin
        gate_cnt_d = gate_cnt_q - 1'b1;
        if (rise) begin
          if (&edge_cnt_q) ovf_d = 1'b1;
          else             edge_cnt_d = edge_cnt_q + 1'b1;
        end
        // Results are registered on entry to DONE so they coincide with the valid pulse.
        if (gate_cnt_q == GATE_W'(1)) begin
          state_d    = StDone;
          diff       = (edge_cnt_d >= exp_q) ? (edge_cnt_d - exp_q) : (exp_q - edge_cnt_d);
          count_d    = edge_cnt_d;
          overflow_d = ovf_d;
          lock_d     = !ovf_d && (diff <= tol_q);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      exp_q      <= '0;
      tol_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in_i;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      exp_q      <= exp_d;
      tol_q      <= tol_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      lock_q     <= lock_d;
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign lock_o     = lock_q;

endmodule
